// File: rtl/axi_mem_responder_pkg.sv
// Shared types and constants for the AXI4 burst memory responder.
package axi_mem_responder_pkg;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_mem_responder_lfsr.sv
// 16-bit Fibonacci LFSR that drives the pseudo-random handshake stalls.
module axi_mem_responder_lfsr
  import axi_mem_responder_pkg::*;
#(
  parameter logic [15:0] C_SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= C_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR burst memory slave, one outstanding burst per direction.
// Define AXI_MEM_RESPONDER_BACKPRESSURE_EN to add LFSR-driven handshake stalls.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 64,
  parameter int          C_M_AXI_DATA_WIDTH = 512,
  parameter int          C_MEM_DEPTH        = 1024,
  parameter logic [15:0] C_LFSR_SEED        = 16'hACE1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic [31:0]                     rd_burst_cnt,
  output logic [31:0]                     wr_burst_cnt,
  output logic                            wlast_err
);

  localparam int IDX_W  = idx_width(C_MEM_DEPTH);
  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef logic [IDX_W-1:0] idx_t;

  if (C_LFSR_SEED == 16'h0 || C_M_AXI_DATA_WIDTH < 32 || C_M_AXI_DATA_WIDTH > 1024 ||
      (C_M_AXI_DATA_WIDTH & (C_M_AXI_DATA_WIDTH - 1)) != 0 ||
      (C_MEM_DEPTH & (C_MEM_DEPTH - 1)) != 0) begin : g_bad_param
    $error("axi_mem_responder: illegal parameter value");
  end

  logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_DEPTH];

  rd_state_t   rd_state_q, rd_state_d;
  wr_state_t   wr_state_q, wr_state_d;
  idx_t        rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [7:0]  rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic        wlast_err_q, wlast_err_d;
  logic        live_q;
  logic        gate_ar, gate_aw, gate_w, gate_r;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

`ifdef AXI_MEM_RESPONDER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  axi_mem_responder_lfsr #(
    .C_SEED (C_LFSR_SEED)
  ) u_lfsr (
    .clk_i  (aclk),
    .rst_i  (areset),
    .lfsr_o (lfsr)
  );

  assign gate_ar     = lfsr[0];
  assign gate_aw     = lfsr[4];
  assign gate_w      = lfsr[8];
  assign gate_r      = lfsr[12];
  assign unused_lfsr = ^{lfsr[15:13], lfsr[11:9], lfsr[7:5], lfsr[3:1]};
`else
  assign gate_ar = 1'b1;
  assign gate_aw = 1'b1;
  assign gate_w  = 1'b1;
  assign gate_r  = 1'b1;
`endif

  // Readies stay low until the first cycle after reset is released.
  assign s_axi_arready = live_q & ~areset & (rd_state_q == R_IDLE) & gate_ar;
  assign s_axi_awready = live_q & ~areset & (wr_state_q == W_IDLE) & gate_aw;
  assign s_axi_wready  = live_q & ~areset & (wr_state_q == W_DATA) & gate_w;
  assign s_axi_rvalid  = (rd_state_q == R_DATA) & gate_r;
  assign s_axi_bvalid  = (wr_state_q == W_RESP);
  assign s_axi_rlast   = (rd_state_q == R_DATA) && (rd_rem_q == 8'd0);
  assign s_axi_rdata   = (rd_state_q == R_DATA) ? mem_q[rd_idx_q] : '0;

  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid  & s_axi_rready;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign b_hs  = s_axi_bvalid  & s_axi_bready;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_rem_d   = rd_rem_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_idx_d   = s_axi_araddr[OFF_W +: IDX_W];
          rd_rem_d   = s_axi_arlen;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rd_idx_d = rd_idx_q + idx_t'(1);
          rd_rem_d = rd_rem_q - 8'd1;
          if (rd_rem_q == 8'd0) begin
            rd_state_d = R_IDLE;
            rd_cnt_d   = rd_cnt_q + 32'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_rem_d    = wr_rem_q;
    wr_cnt_d    = wr_cnt_q;
    wlast_err_d = wlast_err_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          wr_idx_d   = s_axi_awaddr[OFF_W +: IDX_W];
          wr_rem_d   = s_axi_awlen;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          // Burst length always follows awlen; a bad wlast is only flagged.
          if (s_axi_wlast != (wr_rem_q == 8'd0)) wlast_err_d = 1'b1;
          wr_idx_d = wr_idx_q + idx_t'(1);
          wr_rem_d = wr_rem_q - 8'd1;
          if (wr_rem_q == 8'd0) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_cnt_d   = wr_cnt_q + 32'd1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q  <= R_IDLE;
      wr_state_q  <= W_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      wlast_err_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      wlast_err_q <= wlast_err_d;
      live_q      <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    rd_idx_q <= rd_idx_d;
    rd_rem_q <= rd_rem_d;
    wr_idx_q <= wr_idx_d;
    wr_rem_q <= wr_rem_d;
  end

  // Registered write, combinational read: a same-cycle read sees the old word.
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[wr_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign rd_burst_cnt = rd_cnt_q;
  assign wr_burst_cnt = wr_cnt_q;
  assign wlast_err    = wlast_err_q;

  logic unused_addr;
  assign unused_addr = ^{s_axi_araddr, s_axi_awaddr};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a word-array memory model.
module tb_axi_mem_responder;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int SW    = DW / 8;
  localparam int OFF   = 6;
  localparam int DEPTH = 64;
  localparam int LIM   = 64;
`ifdef AXI_MEM_RESPONDER_BACKPRESSURE_EN
  localparam int NRND = 1000;
`else
  localparam int NRND = 300;
`endif

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [SW-1:0] s_axi_wstrb = '0;
  logic          s_axi_wlast = 1'b0;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [AW-1:0] s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast;
  logic [31:0]   rd_burst_cnt;
  logic [31:0]   wr_burst_cnt;
  logic          wlast_err;

  axi_mem_responder #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_MEM_DEPTH        (DEPTH),
    .C_LFSR_SEED        (16'hACE1)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .rd_burst_cnt  (rd_burst_cnt),
    .wr_burst_cnt  (wr_burst_cnt),
    .wlast_err     (wlast_err)
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf_d [256];
  logic [SW-1:0] wbuf_s [256];
  int unsigned   exp_rd = 0;
  int unsigned   exp_wr = 0;
  logic          exp_err = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] rnd_strb();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input int idx, input int len, input int early, input bit rnd);
    int n;
    bit got;
    s_axi_awaddr  = AW'(idx) << OFF;
    s_axi_awlen   = 8'(len);
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < LIM) begin step(); n++; end
    if (!s_axi_awready) chk("aw_ready", DW'(s_axi_awready), DW'(1));
    step();
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_axi_wdata  = wbuf_d[b];
      s_axi_wstrb  = wbuf_s[b];
      s_axi_wlast  = (b == len) || (b == early);
      s_axi_wvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      got = 1'b0;
      n = 0;
      while (!got && n < LIM) begin
        if (!s_axi_wvalid) s_axi_wvalid = 1'($urandom_range(0, 1));
        if (s_axi_wvalid && s_axi_wready) begin
          for (int k = 0; k < SW; k++)
            if (wbuf_s[b][k]) ref_mem[(idx + b) % DEPTH][8*k +: 8] = wbuf_d[b][8*k +: 8];
          got = 1'b1;
        end
        step();
        n++;
      end
      if (!got) chk("w_ready", DW'(s_axi_wready), DW'(1));
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    if (early >= 0 && early != len) exp_err = 1'b1;
    chk("b_after_last", DW'(s_axi_bvalid), DW'(1));
    if (rnd) repeat ($urandom_range(0, 2)) step();
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    exp_wr++;
    chk("wr_burst_cnt", DW'(wr_burst_cnt), DW'(exp_wr));
    chk("b_clear", DW'(s_axi_bvalid), DW'(0));
    chk("wlast_err", DW'(wlast_err), DW'(exp_err));
  endtask

  task automatic do_read(input int idx, input int len, input bit rnd);
    int n;
    bit got;
    s_axi_araddr  = AW'(idx) << OFF;
    s_axi_arlen   = 8'(len);
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < LIM) begin step(); n++; end
    if (!s_axi_arready) chk("ar_ready", DW'(s_axi_arready), DW'(1));
    step();
    s_axi_arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      got = 1'b0;
      n = 0;
`ifndef AXI_MEM_RESPONDER_BACKPRESSURE_EN
      if (!rnd) chk("r_stream", DW'(s_axi_rvalid), DW'(1));
`endif
      while (!got && n < LIM) begin
        s_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (s_axi_rvalid && s_axi_rready) begin
          chk("rdata", s_axi_rdata, ref_mem[(idx + b) % DEPTH]);
          chk("rlast", DW'(s_axi_rlast), DW'(b == len));
          got = 1'b1;
        end
        step();
        n++;
      end
      if (!got) chk("r_valid", DW'(s_axi_rvalid), DW'(1));
    end
    s_axi_rready = 1'b0;
    exp_rd++;
    chk("rd_burst_cnt", DW'(rd_burst_cnt), DW'(exp_rd));
    chk("r_done", DW'(s_axi_rvalid), DW'(0));
  endtask

  initial begin
    int n;
    int idx;
    int len;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arready", DW'(s_axi_arready), DW'(0));
    chk("rst_awready", DW'(s_axi_awready), DW'(0));
    chk("rst_wready", DW'(s_axi_wready), DW'(0));
    chk("rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    chk("rst_bvalid", DW'(s_axi_bvalid), DW'(0));
    chk("rst_rlast", DW'(s_axi_rlast), DW'(0));
    chk("rst_rdata", s_axi_rdata, DW'(0));
    chk("rst_rd_cnt", DW'(rd_burst_cnt), DW'(0));
    chk("rst_wr_cnt", DW'(wr_burst_cnt), DW'(0));
    chk("rst_wlast_err", DW'(wlast_err), DW'(0));
    areset = 1'b0;
    step();
`ifndef AXI_MEM_RESPONDER_BACKPRESSURE_EN
    chk("post_rst_arready", DW'(s_axi_arready), DW'(1));
    chk("post_rst_awready", DW'(s_axi_awready), DW'(1));
`endif

    // All-ones background across the whole memory.
    for (int i = 0; i < DEPTH; i++) begin wbuf_d[i] = '1; wbuf_s[i] = '1; end
    do_write(0, DEPTH - 1, -1, 1'b0);

    for (int i = 0; i < 4; i++) begin wbuf_d[i] = DW'(i + 1); wbuf_s[i] = '1; end
    do_write(1, 3, -1, 1'b0);
    do_read(1, 3, 1'b0);

    wbuf_d[0] = rnd_word();
    wbuf_s[0] = '1;
    do_write(0, 0, -1, 1'b0);
    do_read(DEPTH - 1, 1, 1'b0);

    wbuf_d[0] = rnd_word();
    wbuf_s[0] = SW'(64'h0F);
    do_write(10, 0, -1, 1'b0);
    do_read(10, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin wbuf_d[i] = rnd_word(); wbuf_s[i] = '1; end
    do_write(20, 3, 1, 1'b0);
    do_read(20, 3, 1'b0);

    for (int i = 0; i < 4; i++) begin wbuf_d[i] = rnd_word(); wbuf_s[i] = rnd_strb(); end
    do_write(DEPTH - 2, 3, -1, 1'b0);
    do_read(DEPTH - 2, 3, 1'b0);

    // Reset lands while the second beat of a read is on the bus.
    s_axi_araddr  = AW'(1) << OFF;
    s_axi_arlen   = 8'd3;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < LIM) begin step(); n++; end
    step();
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < LIM) begin step(); n++; end
    step();
    areset = 1'b1;
    step();
    chk("mid_rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    chk("mid_rst_arready", DW'(s_axi_arready), DW'(0));
    chk("mid_rst_rd_cnt", DW'(rd_burst_cnt), DW'(0));
    chk("mid_rst_wlast_err", DW'(wlast_err), DW'(0));
    areset = 1'b0;
    s_axi_rready = 1'b0;
    exp_rd  = 0;
    exp_wr  = 0;
    exp_err = 1'b0;
    step();
`ifndef AXI_MEM_RESPONDER_BACKPRESSURE_EN
    chk("rel_rst_arready", DW'(s_axi_arready), DW'(1));
`endif
    chk("rel_rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    do_read(1, 3, 1'b0);

    for (int t = 0; t < NRND; t++) begin
      idx = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wbuf_d[i] = rnd_word(); wbuf_s[i] = rnd_strb(); end
        do_write(idx, len, -1, 1'b1);
      end else begin
        do_read(idx, len, 1'b1);
      end
    end
    chk("final_wlast_err", DW'(wlast_err), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64, byte-address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 512, data-beat width; legal values are powers of two from 32 to 1024.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 1024, number of data-width words; must be a power of two.
REQ-004 SHALL have parameter C_LFSR_SEED, default 16'hACE1, backpressure LFSR seed; must be non-zero.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with the clock and reset ports named as the codebase does:
- aclk  in  1  clock, rising edge.
- areset  in  1  synchronous active-high reset.
REQ-006 Write address channel:
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_awaddr  in  ADDR
- s_axi_awlen  in  8
REQ-007 Write data channel:
- s_axi_wvalid  in  1
- s_axi_wready  out  1
- s_axi_wdata  in  DATA
- s_axi_wstrb  in  DATA/8
- s_axi_wlast  in  1
REQ-008 Write response channel:
- s_axi_bvalid  out  1
- s_axi_bready  in  1
REQ-009 Read address channel:
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_araddr  in  ADDR
- s_axi_arlen  in  8
REQ-010 Read data channel:
- s_axi_rvalid  out  1
- s_axi_rready  in  1
- s_axi_rdata  out  DATA
- s_axi_rlast  out  1
REQ-011 Status outputs:
- rd_burst_cnt  out  32  count of completed read bursts.
- wr_burst_cnt  out  32  count of completed B handshakes.
- wlast_err  out  1  sticky protocol error flag.

Function
REQ-012 SHALL respond to the AXI4 master as an INCR burst memory, with one outstanding burst per direction; read and write paths operate independently and concurrently.
REQ-013 Read FSM SHALL have states:
- R_IDLE: arready=1. An AR handshake captures word index = araddr[...:log2(DATA/8)] mod C_MEM_DEPTH and remaining = arlen, then goes to R_DATA.
- R_DATA: rvalid=1 and rdata=mem[index]. On each R handshake, index increments modulo C_MEM_DEPTH. rlast=1 when remaining=0. The handshake on the last beat returns to R_IDLE and increments rd_burst_cnt.
REQ-014 The first rvalid SHALL assert the cycle after the AR handshake; beats SHALL stream at one per cycle while rready=1.
REQ-015 Write FSM SHALL have states:
- W_IDLE: awready=1. An AW handshake captures index and length as in REQ-013, then goes to W_DATA.
- W_DATA: wready=1. Each W handshake writes the bytes of mem[index] whose wstrb bit is set, then increments index with wrap.
- The beat with remaining=0 goes to W_RESP.
- W_RESP: bvalid=1 until bready, then increments wr_burst_cnt and returns to W_IDLE.
REQ-016 If wlast mismatches remaining=0 on a beat, wlast_err SHALL set and stay set until reset; the burst length is taken from awlen regardless.
REQ-017 A write to the word being read in the same cycle SHALL be visible to the read on the next cycle; the current beat returns the old data.
REQ-018 Index wrap from C_MEM_DEPTH-1 to 0 inside a burst SHALL be silent, with no error.
REQ-019 Counters SHALL wrap at 2^32.

Reset
REQ-020 Under areset:
- outputs: arready=awready=wready=0, rvalid=bvalid=rlast=0, rdata=0, counters=0, wlast_err=0.
- FSMs go to R_IDLE and W_IDLE; ready signals assert the first cycle after reset deasserts.
REQ-021 Reset mid-burst SHALL abandon the burst with no B or R completion. Memory contents SHALL NOT be reset.

Configuration
REQ-022 Macro AXI_MEM_RESPONDER_BACKPRESSURE_EN:
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded C_LFSR_SEED at reset) advances every cycle. arready, awready, wready and rvalid are each gated by a distinct LFSR bit, giving roughly 50% stall. rdata and rlast SHALL stay stable while rvalid is gated low mid-burst.
- Undefined: no gating, and no LFSR logic is synthesised.

Structure
REQ-023 Package axi_mem_responder_pkg SHALL hold the rd_state_t/wr_state_t enums, the LFSR tap constant and a localparam function for the word-index width.
REQ-024 The LFSR SHALL be sub-module axi_mem_responder_lfsr, instantiated only when the macro is defined.

Verification
REQ-025 Write AW addr 0x40, len 3, four beats of data 1..4 with full strobes -> B after the last beat, mem[1..4]=1..4, wr_burst_cnt=1.
REQ-026 Read AR addr 0x40, len 3, rready=1 -> rdata 1,2,3,4 on four consecutive cycles, rlast on the 4th beat, rd_burst_cnt=1.
REQ-027 Read at word C_MEM_DEPTH-1, len 1 -> beats mem[C_MEM_DEPTH-1] then mem[0].
REQ-028 Write with wstrb=0x0F over 0xFF.. background -> only the low 4 bytes change; wlast early on beat 1 of a len-3 burst -> wlast_err=1.
REQ-029 Assert areset during beat 2 of a read -> rvalid=0 next cycle, arready=1 two cycles later, memory intact.
REQ-030 With the macro defined, 1000 random bursts against a reference model -> data matches, no handshake dropped.
